// File: rtl/tb_run_ctrl_pkg.sv
// tb_run_ctrl_pkg: shared FSM state, final status codes and widths for the run controller
package tb_run_ctrl_pkg;
    localparam int STATUS_W = 3;
    localparam int HOLD_W   = 8;
    typedef enum logic [1:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        DONE
    } run_state_e;
    typedef enum logic [STATUS_W-1:0] {
        ST_NONE     = 3'd0,
        ST_PASS     = 3'd1,
        ST_FAIL     = 3'd2,
        ST_EXIT_OK  = 3'd3,
        ST_EXIT_ERR = 3'd4,
        ST_TIMEOUT  = 3'd5,
        ST_ABORT    = 3'd6
    } run_status_e;
endpackage

// File: rtl/tb_sat_counter.sv
// tb_sat_counter: clearable up-counter that sticks at all-ones instead of wrapping
module tb_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_o <= '0;
        else if (clr_i) cnt_o <= '0;
        else if (en_i && cnt_o != '1) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/tb_run_ctrl.sv
// tb_run_ctrl: sequences core reset/fetch enable, counts run cycles and latches one final status
module tb_run_ctrl
    import tb_run_ctrl_pkg::*;
#(
    parameter int RESET_WAIT_CYCLES = 4,
    parameter int CNT_W             = 32,
    parameter int EXIT_W            = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [CNT_W-1:0]    max_cycles_i,
    input  logic                tests_passed_i,
    input  logic                tests_failed_i,
    input  logic                exit_valid_i,
    input  logic [EXIT_W-1:0]   exit_value_i,
    output logic                core_rst_no,
    output logic                fetch_enable_o,
    output logic                running_o,
    output logic                done_o,
    output logic [STATUS_W-1:0] status_o,
    output logic [EXIT_W-1:0]   exit_value_o,
    output logic [CNT_W-1:0]    cycle_cnt_o
);
    run_state_e        state_q, state_d;
    run_status_e       status_q, ev_status;
    logic [CNT_W-1:0]  max_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              in_run, go, hold_done, timeout, exit_ev, ev;

    // wrapper inputs may be X outside RUN, so every use is qualified by in_run
    assign in_run    = state_q == RUN;
    assign go        = start_i && (state_q == IDLE || state_q == DONE);
    assign hold_done = state_q == RESET_HOLD && hold_cnt == HOLD_W'(RESET_WAIT_CYCLES - 1);
    assign timeout   = in_run && max_q != '0 && cycle_cnt_o >= max_q;
    assign exit_ev   = in_run && exit_valid_i;
    assign ev        = ev_status != ST_NONE;
    assign status_o  = status_q;

    always_comb begin
        ev_status = (in_run && abort_i)               ? ST_ABORT    :
                    (in_run && tests_failed_i)        ? ST_FAIL     :
                    (exit_ev && exit_value_i != '0)   ? ST_EXIT_ERR :
                    exit_ev                           ? ST_EXIT_OK  :
                    (in_run && tests_passed_i)        ? ST_PASS     :
                    timeout                           ? ST_TIMEOUT  : ST_NONE;
        state_d   = go        ? RESET_HOLD :
                    hold_done ? RUN        :
                    ev        ? DONE       : state_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            core_rst_no    <= 1'b0;
            fetch_enable_o <= 1'b0;
            running_o      <= 1'b0;
            done_o         <= 1'b0;
            status_q       <= ST_NONE;
            exit_value_o   <= '0;
            max_q          <= '0;
        end else begin
            core_rst_no    <= state_d == RUN;
            fetch_enable_o <= state_d == RUN;
            running_o      <= state_d == RUN;
            done_o         <= state_d == DONE;
            if (go) begin
                status_q     <= ST_NONE;
                exit_value_o <= '0;
                max_q        <= max_cycles_i;
            end else if (ev) begin
                status_q <= ev_status;
                if (ev_status == ST_EXIT_OK || ev_status == ST_EXIT_ERR) exit_value_o <= exit_value_i;
            end
        end

    tb_sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (go),
        .en_i   (state_q == RESET_HOLD),
        .cnt_o  (hold_cnt)
    );

    tb_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (go),
        .en_i   (in_run && !ev),
        .cnt_o  (cycle_cnt_o)
    );
endmodule

// File: tb/tb_tb_run_ctrl.sv
// tb_tb_run_ctrl: randomized run scenarios scored against a per-run outcome model
module tb_tb_run_ctrl;
    import tb_run_ctrl_pkg::*;
    localparam int R = 4;

    logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic [31:0] max_cycles_i = '0;
    logic        tests_passed_i, tests_failed_i, exit_valid_i;
    logic [31:0] exit_value_i;
    logic        core_rst_no, fetch_enable_o, running_o, done_o;
    logic [2:0]  status_o;
    logic [31:0] exit_value_o, cycle_cnt_o;

    tb_run_ctrl #(.RESET_WAIT_CYCLES(R), .CNT_W(32), .EXIT_W(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .max_cycles_i   (max_cycles_i),
        .tests_passed_i (tests_passed_i),
        .tests_failed_i (tests_failed_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .core_rst_no    (core_rst_no),
        .fetch_enable_o (fetch_enable_o),
        .running_o      (running_o),
        .done_o         (done_o),
        .status_o       (status_o),
        .exit_value_o   (exit_value_o),
        .cycle_cnt_o    (cycle_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] ev;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_chk = 0, n_fail = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // outcome of one run from the event rules: earliest cycle wins, priority among same-cycle events
    function automatic exp_t model(input int m, input int n, input bit ab, input bit fl,
                                   input bit ex, input bit pa, input logic [31:0] val);
        exp_t e;
        e.ev  = '0;
        e.cnt = n;
        if (m != 0 && (!(ab || fl || ex || pa) || m < n)) begin
            e.st  = 3'd5;
            e.cnt = m;
        end else if (ab) e.st = 3'd6;
        else if (fl) e.st = 3'd2;
        else if (ex) begin
            e.st = (val != 0) ? 3'd4 : 3'd3;
            e.ev = val;
        end else e.st = 3'd1;
        return e;
    endfunction

    task automatic x_wrapper();
        tests_passed_i = 'x; tests_failed_i = 'x; exit_valid_i = 'x; exit_value_i = 'x;
    endtask

    task automatic zero_wrapper();
        tests_passed_i = 0; tests_failed_i = 0; exit_valid_i = 0; exit_value_i = $urandom;
    endtask

    task automatic start_run(input int m, input bit ab_hold);
        x_wrapper();
        @(posedge clk_i); #1;
        start_i = 1; max_cycles_i = m;
        @(posedge clk_i); #1;
        start_i = 0; max_cycles_i = $urandom_range(1, 3); abort_i = ab_hold;
        chk("start_done_clr", done_o, 0);
        chk("start_status_clr", status_o, 0);
        chk("start_exit_clr", exit_value_o, 0);
        chk("start_cnt_clr", cycle_cnt_o, 0);
        chk("hold_rst_lo", core_rst_no, 0);
        for (int i = 0; i < R - 1; i++) begin
            @(posedge clk_i); #1;
            chk("hold_rst_lo", core_rst_no, 0);
            chk("hold_fetch_lo", fetch_enable_o, 0);
        end
        @(posedge clk_i); #1;
        abort_i = 0;
        zero_wrapper();
        chk("run_rst_hi", core_rst_no, 1);
        chk("run_fetch_hi", fetch_enable_o, 1);
        chk("run_running", running_o, 1);
        chk("run_cnt0", cycle_cnt_o, 0);
    endtask

    task automatic run_body(input int m, input int n, input bit ab, input bit fl,
                            input bit ex, input bit pa, input logic [31:0] val);
        exp_t e;
        int c = 0;
        int lim;
        e = model(m, n, ab, fl, ex, pa, val);
        q.push_back(e);
        lim = int'(e.cnt) + 5;
        while (!done_o && c <= lim) begin
            chk("cycle_cnt", cycle_cnt_o, c);
            if (c == n) begin
                abort_i = ab; tests_failed_i = fl; exit_valid_i = ex; tests_passed_i = pa; exit_value_i = val;
            end else begin
                abort_i = 0;
                zero_wrapper();
            end
            @(posedge clk_i); #1;
            c++;
        end
        chk("done_seen", done_o, 1);
        x_wrapper();
        abort_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        abort_i = 0;
        chk("done_hold", done_o, 1);
        chk("done_status_hold", status_o, e.st);
        chk("done_cnt_hold", cycle_cnt_o, e.cnt);
        chk("done_rst_lo", core_rst_no, 0);
    endtask

    always @(negedge clk_i) begin
        if (done_o && !prev_done) begin
            if (q.size() == 0) chk("unexpected_done", done_o, 0);
            else begin
                me = q.pop_front();
                chk("status", status_o, me.st);
                chk("exit_value", exit_value_o, me.ev);
                chk("final_cnt", cycle_cnt_o, me.cnt);
                chk("quiesce_rst", core_rst_no, 0);
                chk("quiesce_fetch", fetch_enable_o, 0);
                chk("quiesce_running", running_o, 0);
            end
        end
        prev_done = done_o;
    end

    initial begin
        x_wrapper();
        #1;
        chk("rst_core_rst", core_rst_no, 0);
        chk("rst_fetch", fetch_enable_o, 0);
        chk("rst_running", running_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_status", status_o, 0);
        chk("rst_exit", exit_value_o, 0);
        chk("rst_cnt", cycle_cnt_o, 0);
        #21 rst_ni = 1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("idle_rst_lo", core_rst_no, 0);
        start_run(0, 0);    run_body(0, 20, 0, 0, 1, 0, 0);
        start_run(50, 0);   run_body(50, 1000, 0, 0, 0, 0, 0);
        start_run(50, 0);   run_body(50, 50, 0, 0, 0, 1, 0);
        start_run(0, 0);    run_body(0, 15, 0, 1, 1, 1, 7);
        start_run(0, 0);    run_body(0, 15, 0, 0, 1, 1, 7);
        start_run(0, 1);    run_body(0, 10, 1, 0, 0, 0, 0);
        for (int k = 0; k < 25; k++) begin
            int m, n;
            bit ab, fl, ex, pa;
            logic [31:0] val;
            m  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            n  = $urandom_range(0, 60);
            ab = ($urandom_range(0, 4) == 0);
            fl = $urandom_range(0, 1);
            ex = $urandom_range(0, 1);
            pa = $urandom_range(0, 1);
            val = $urandom_range(0, 1) ? 32'd0 : $urandom;
            if (m == 0 && !(ab || fl || ex || pa)) pa = 1;
            start_run(m, $urandom_range(0, 1));
            run_body(m, n, ab, fl, ex, pa, val);
        end
        start_run(0, 0);
        repeat (30) @(posedge clk_i);
        #1;
        chk("pre_reset_cnt", cycle_cnt_o, 30);
        #2 rst_ni = 0;
        #1;
        chk("async_core_rst", core_rst_no, 0);
        chk("async_fetch", fetch_enable_o, 0);
        chk("async_running", running_o, 0);
        chk("async_done", done_o, 0);
        chk("async_status", status_o, 0);
        chk("async_exit", exit_value_o, 0);
        chk("async_cnt", cycle_cnt_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("idle_after_rst", core_rst_no, 0);
        chk("idle_after_rst_run", running_o, 0);
        start_run(0, 0);    run_body(0, 65546, 1, 0, 0, 0, 0);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
